instruction_decode: RTL and testbench

Decode/operand-read stage of the 20-bit pipeline processor. It is the producer side of the execute-stage interface.
- Accepts a fetched instruction and reads operands from an internal register file.
- Tracks in-flight writers with a per-register scoreboard and stalls on RAW hazards.
- Registers instruction/control/opA/opB into the ID/EX pipeline register consumed by execute.

---
 rtl/decode_pkg.sv | 35 +++
 rtl/instruction_decode_register_file.sv | 38 +++
 rtl/instruction_decode.sv | 222 ++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants for the decode/operand-read stage
// Purpose: opcode encodings, ALU control codes, NOP encoding, instruction
//          field bit positions and register count used by instruction_decode.
// Ports:   none (package)
package decode_pkg;

  localparam int REG_COUNT = 8;

  // Instruction field bit positions
  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 13;
  localparam int RS_HI  = 12;
  localparam int RS_LO  = 10;
  localparam int RT_HI  = 9;
  localparam int RT_LO  = 7;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b0100;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_OR  = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_ctrl_e;

  localparam logic [19:0] NOP_INSTR = 20'hF0000;

endpackage

// File: rtl/instruction_decode_register_file.sv
// rtl/instruction_decode_register_file.sv - 8-entry register file, r0 reads zero
// Purpose: operand storage for the decode stage.
// Ports:   clock, reset (sync active-low)
//          i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b : combinational read ports
//          i_wen/i_waddr/i_wdata                    : synchronous write port
module register_file
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_raddr_a,
  output logic [DATA_WIDTH-1:0] o_rdata_a,
  input  logic [ADDR_WIDTH-1:0] i_raddr_b,
  output logic [DATA_WIDTH-1:0] o_rdata_b,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata
);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wen && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - decode/operand-read stage with RAW scoreboard
// Purpose: decodes fetched instructions, reads operands, stalls on pending
//          writers and fills the ID/EX register consumed by execute.
// Ports:   clock, reset (sync active-low)
//          inValid/inReady/inInstruction : fetch handshake
//          flush/outStall                : execute-side control
//          outValid..outWrAddr           : ID/EX register contents
//          illegal                       : one-cycle pulse on illegal opcode accept
//          wbEnable/wbAddr/wbData        : writeback port
// Option:  DECODE_WB_BYPASS_EN forwards same-cycle writeback data to operands.
module instruction_decode
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH     = 20,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int CNT_WIDTH      = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [DATA_WIDTH-1:0]     inInstruction,
  input  logic                      flush,
  input  logic                      outStall,
  output logic                      outValid,
  output logic [DATA_WIDTH-1:0]     outInstruction,
  output logic [1:0]                outControl,
  output logic [DATA_WIDTH-1:0]     outOpA,
  output logic [DATA_WIDTH-1:0]     outOpB,
  output logic                      outBranch,
  output logic                      outWrEnable,
  output logic [REG_ADDR_WIDTH-1:0] outWrAddr,
  output logic                      illegal,
  input  logic                      wbEnable,
  input  logic [REG_ADDR_WIDTH-1:0] wbAddr,
  input  logic [DATA_WIDTH-1:0]     wbData
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(2);

  // Decode
  logic [3:0]                w_opcode;
  logic [REG_ADDR_WIDTH-1:0] w_rd, w_rs, w_rt;
  logic                      w_reads_rs, w_reads_rt, w_writes, w_legal, w_branch;
  alu_ctrl_e                 w_ctrl;

  assign w_opcode = inInstruction[OPC_HI:OPC_LO];
  assign w_rd     = inInstruction[RD_HI:RD_LO];
  assign w_rs     = inInstruction[RS_HI:RS_LO];
  assign w_rt     = inInstruction[RT_HI:RT_LO];

  always_comb begin
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    w_writes   = 1'b0;
    w_legal    = 1'b1;
    w_branch   = 1'b0;
    w_ctrl     = ALU_ADD;
    case (w_opcode)
      OP_ADD: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_writes = 1'b1; end
      OP_OR:  begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_writes = 1'b1; w_ctrl = ALU_OR;  end
      OP_AND: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_writes = 1'b1; w_ctrl = ALU_AND; end
      OP_NOT: begin w_reads_rs = 1'b1; w_writes = 1'b1; w_ctrl = ALU_NOT; end
      OP_BEQ: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; w_branch = 1'b1; end
      OP_NOP: ;
      default: w_legal = 1'b0;
    endcase
  end

  // Register file and scoreboard
  logic [DATA_WIDTH-1:0] w_rf_a, w_rf_b;
  logic [CNT_WIDTH-1:0]  r_cnt    [REG_COUNT];
  logic [CNT_WIDTH-1:0]  w_cnt_nx [REG_COUNT];

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_register_file (
    .clock     (clock),
    .reset     (reset),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rf_a),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rf_b),
    .i_wen     (wbEnable),
    .i_waddr   (wbAddr),
    .i_wdata   (wbData)
  );

  // A source whose only outstanding writer retires this cycle can take wbData directly.
  logic w_byp_rs, w_byp_rt;
`ifdef DECODE_WB_BYPASS_EN
  assign w_byp_rs = wbEnable && (wbAddr == w_rs) && (r_cnt[w_rs] == CNT_ONE);
  assign w_byp_rt = wbEnable && (wbAddr == w_rt) && (r_cnt[w_rt] == CNT_ONE);
`else
  assign w_byp_rs = 1'b0;
  assign w_byp_rt = 1'b0;
`endif

  logic w_rs_pend, w_rt_pend, w_dest_full, w_accept;
  logic r_out_valid, r_out_we;
  logic [REG_ADDR_WIDTH-1:0] r_out_wa;

  assign w_rs_pend   = w_reads_rs && (w_rs != '0) && (r_cnt[w_rs] != '0) && !w_byp_rs;
  assign w_rt_pend   = w_reads_rt && (w_rt != '0) && (r_cnt[w_rt] != '0) && !w_byp_rt;
  assign w_dest_full = w_writes && (r_cnt[w_rd] == CNT_MAX);

  assign inReady  = !flush && !(r_out_valid && outStall) && !w_rs_pend && !w_rt_pend && !w_dest_full;
  assign w_accept = inValid && inReady;

  // Per-register increment (issue) and decrement (writeback, flushed entry) strobes
  logic [REG_COUNT-1:0] w_inc, w_dec_wb, w_dec_fl;

  always_comb begin
    w_inc    = '0;
    w_dec_wb = '0;
    w_dec_fl = '0;
    if (w_accept && w_writes)                  w_inc[w_rd]       = 1'b1;
    if (wbEnable)                              w_dec_wb[wbAddr]  = 1'b1;
    if (flush && r_out_valid && r_out_we)      w_dec_fl[r_out_wa] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      w_cnt_nx[i] = r_cnt[i];
      case ({w_inc[i], w_dec_wb[i], w_dec_fl[i]})
        3'b100:                 w_cnt_nx[i] = r_cnt[i] + CNT_ONE;
        3'b010, 3'b001, 3'b111: w_cnt_nx[i] = (r_cnt[i] != '0) ? r_cnt[i] - CNT_ONE : '0;
        3'b011:                 w_cnt_nx[i] = (r_cnt[i] > CNT_ONE) ? r_cnt[i] - CNT_TWO : '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < REG_COUNT; i++) begin
      if (!reset || (i == 0)) r_cnt[i] <= '0;
      else                    r_cnt[i] <= w_cnt_nx[i];
    end
  end

  // ID/EX register
  logic [DATA_WIDTH-1:0] w_op_a, w_op_b;
  assign w_op_a = w_reads_rs ? (w_byp_rs ? wbData : w_rf_a) : '0;
  assign w_op_b = w_reads_rt ? (w_byp_rt ? wbData : w_rf_b) : '0;

  logic [DATA_WIDTH-1:0]     r_out_inst, r_out_opa, r_out_opb;
  logic [1:0]                r_out_ctrl;
  logic                      r_out_br, r_illegal;
  logic                      w_nx_valid, w_nx_we, w_nx_br;
  logic [DATA_WIDTH-1:0]     w_nx_inst, w_nx_opa, w_nx_opb;
  logic [1:0]                w_nx_ctrl;
  logic [REG_ADDR_WIDTH-1:0] w_nx_wa;

  // Default is a bubble; flush, illegal and idle cycles all fall through to it.
  always_comb begin
    w_nx_valid = 1'b0;
    w_nx_inst  = DATA_WIDTH'(NOP_INSTR);
    w_nx_ctrl  = 2'b00;
    w_nx_opa   = '0;
    w_nx_opb   = '0;
    w_nx_br    = 1'b0;
    w_nx_we    = 1'b0;
    w_nx_wa    = '0;
    if (!flush && r_out_valid && outStall) begin
      w_nx_valid = r_out_valid;
      w_nx_inst  = r_out_inst;
      w_nx_ctrl  = r_out_ctrl;
      w_nx_opa   = r_out_opa;
      w_nx_opb   = r_out_opb;
      w_nx_br    = r_out_br;
      w_nx_we    = r_out_we;
      w_nx_wa    = r_out_wa;
    end else if (!flush && w_accept && w_legal) begin
      w_nx_valid = 1'b1;
      w_nx_inst  = inInstruction;
      w_nx_ctrl  = w_ctrl;
      w_nx_opa   = w_op_a;
      w_nx_opb   = w_op_b;
      w_nx_br    = w_branch;
      w_nx_we    = w_writes;
      w_nx_wa    = w_writes ? w_rd : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= DATA_WIDTH'(NOP_INSTR);
      r_out_ctrl  <= 2'b00;
      r_out_opa   <= '0;
      r_out_opb   <= '0;
      r_out_br    <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_wa    <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= w_nx_valid;
      r_out_inst  <= w_nx_inst;
      r_out_ctrl  <= w_nx_ctrl;
      r_out_opa   <= w_nx_opa;
      r_out_opb   <= w_nx_opb;
      r_out_br    <= w_nx_br;
      r_out_we    <= w_nx_we;
      r_out_wa    <= w_nx_wa;
      r_illegal   <= w_accept && !w_legal;
    end
  end

  assign outValid       = r_out_valid;
  assign outInstruction = r_out_inst;
  assign outControl     = r_out_ctrl;
  assign outOpA         = r_out_opa;
  assign outOpB         = r_out_opb;
  assign outBranch      = r_out_br;
  assign outWrEnable    = r_out_we;
  assign outWrAddr      = r_out_wa;
  assign illegal        = r_illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - self-checking bench for instruction_decode
module tb_instruction_decode;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, inValid, inReady, flush, outStall, outValid;
  logic        outBranch, outWrEnable, illegal, wbEnable;
  logic [19:0] inInstruction, outInstruction, outOpA, outOpB, wbData;
  logic [1:0]  outControl;
  logic [2:0]  outWrAddr, wbAddr;

  always #5 clock = ~clock;

  instruction_decode dut (
    .clock          (clock),
    .reset          (reset),
    .inValid        (inValid),
    .inReady        (inReady),
    .inInstruction  (inInstruction),
    .flush          (flush),
    .outStall       (outStall),
    .outValid       (outValid),
    .outInstruction (outInstruction),
    .outControl     (outControl),
    .outOpA         (outOpA),
    .outOpB         (outOpB),
    .outBranch      (outBranch),
    .outWrEnable    (outWrEnable),
    .outWrAddr      (outWrAddr),
    .illegal        (illegal),
    .wbEnable       (wbEnable),
    .wbAddr         (wbAddr),
    .wbData         (wbData)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam logic [19:0] NOP = 20'hF0000;

  function automatic logic [19:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 7'b0};
  endfunction

  // Reference model: architectural registers, outstanding-writer counts, ID/EX contents
  int m_regs [8];
  int m_cnt  [8];
  int m_valid, m_inst, m_ctrl, m_opa, m_opb, m_br, m_we, m_wa, m_ill;

  function automatic bit m_fwd(input int s);
    return BYP && s != 0 && m_cnt[s] == 1 && wbEnable && int'(wbAddr) == s;
  endfunction

  function automatic bit m_ready();
    int op, rd, rs, rt;
    bit ra, rb, wr;
    op = int'(inInstruction[19:16]);
    rd = int'(inInstruction[15:13]);
    rs = int'(inInstruction[12:10]);
    rt = int'(inInstruction[9:7]);
    ra = (op <= 4);
    rb = (op <= 2) || (op == 4);
    wr = (op <= 3);
    if (flush) return 0;
    if (m_valid != 0 && outStall) return 0;
    if (ra && rs != 0 && m_cnt[rs] != 0 && !m_fwd(rs)) return 0;
    if (rb && rt != 0 && m_cnt[rt] != 0 && !m_fwd(rt)) return 0;
    if (wr && m_cnt[rd] == 3) return 0;
    return 1;
  endfunction

  task automatic m_bubble();
    m_valid = 0; m_inst = int'(NOP); m_ctrl = 0; m_opa = 0; m_opb = 0;
    m_br = 0; m_we = 0; m_wa = 0;
  endtask

  task automatic m_clock();
    int op, rd, rs, rt, opa, opb;
    bit ra, rb, wr, legal, acc;
    int delta [8];
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
      m_bubble();
      m_ill = 0;
      return;
    end
    op = int'(inInstruction[19:16]);
    rd = int'(inInstruction[15:13]);
    rs = int'(inInstruction[12:10]);
    rt = int'(inInstruction[9:7]);
    ra = (op <= 4);
    rb = (op <= 2) || (op == 4);
    wr = (op <= 3);
    legal = (op <= 4) || (op == 15);
    acc = inValid && m_ready();
    opa = !ra ? 0 : (m_fwd(rs) ? int'(wbData) : m_regs[rs]);
    opb = !rb ? 0 : (m_fwd(rt) ? int'(wbData) : m_regs[rt]);
    for (int i = 0; i < 8; i++) delta[i] = 0;
    if (acc && wr) delta[rd] += 1;
    if (wbEnable) delta[wbAddr] -= 1;
    if (flush && m_valid != 0 && m_we != 0) delta[m_wa] -= 1;
    if (flush) m_bubble();
    else if (m_valid != 0 && outStall) ;
    else if (acc && legal) begin
      m_valid = 1; m_inst = int'(inInstruction);
      m_ctrl = (op == 1) ? 1 : (op == 2) ? 2 : (op == 3) ? 3 : 0;
      m_opa = opa; m_opb = opb; m_br = (op == 4);
      m_we = wr; m_wa = wr ? rd : 0;
    end else m_bubble();
    m_ill = acc && !legal;
    for (int i = 1; i < 8; i++) begin
      m_cnt[i] = m_cnt[i] + delta[i];
      if (m_cnt[i] < 0) m_cnt[i] = 0;
    end
    if (wbEnable && wbAddr != 0) m_regs[wbAddr] = int'(wbData);
  endtask

  // One clock: drive inputs, check inReady, clock, check outputs against the model
  task automatic step(input bit rst, input bit v, input logic [19:0] ins, input bit fl,
                      input bit st, input bit we, input logic [2:0] wa,
                      input logic [19:0] wd, input int exp_rdy);
    reset = rst; inValid = v; inInstruction = ins; flush = fl; outStall = st;
    wbEnable = we; wbAddr = wa; wbData = wd;
    #1;
    if (rst) begin
      check("model.inReady", inReady, m_ready());
      if (exp_rdy >= 0) check("table.inReady", inReady, exp_rdy);
    end
    m_clock();
    @(posedge clock);
    #1;
    check("model.outValid", outValid, m_valid);
    check("model.outInstruction", outInstruction, m_inst);
    check("model.outControl", outControl, m_ctrl);
    check("model.outOpA", outOpA, m_opa);
    check("model.outOpB", outOpB, m_opb);
    check("model.outBranch", outBranch, m_br);
    check("model.outWrEnable", outWrEnable, m_we);
    check("model.outWrAddr", outWrAddr, m_wa);
    check("model.illegal", illegal, m_ill);
  endtask

  task automatic exp_out(input string tag, input bit val, input logic [1:0] ctrl,
                         input logic [19:0] opa, input logic [19:0] opb, input bit we,
                         input logic [2:0] wa, input bit br, input bit ill);
    check({tag, ".outValid"}, outValid, val);
    check({tag, ".outControl"}, outControl, ctrl);
    check({tag, ".outOpA"}, outOpA, opa);
    check({tag, ".outOpB"}, outOpB, opb);
    check({tag, ".outWrEnable"}, outWrEnable, we);
    check({tag, ".outWrAddr"}, outWrAddr, wa);
    check({tag, ".outBranch"}, outBranch, br);
    check({tag, ".illegal"}, illegal, ill);
  endtask

  typedef struct {
    bit          rst, v;
    logic [19:0] ins;
    bit          fl, st, we;
    logic [2:0]  wa;
    logic [19:0] wd;
    int          rdy;
    bit          e_val;
    logic [1:0]  e_ctrl;
    logic [19:0] e_opa, e_opb;
    bit          e_we;
    logic [2:0]  e_wa;
    bit          e_br, e_ill;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit rst, input bit v, input logic [19:0] ins, input bit fl,
                     input bit st, input bit we, input logic [2:0] wa, input logic [19:0] wd,
                     input int rdy, input bit e_val, input logic [1:0] e_ctrl,
                     input logic [19:0] e_opa, input logic [19:0] e_opb, input bit e_we,
                     input logic [2:0] e_wa, input bit e_br, input bit e_ill);
    vec_t t;
    t.rst = rst; t.v = v; t.ins = ins; t.fl = fl; t.st = st; t.we = we; t.wa = wa; t.wd = wd;
    t.rdy = rdy; t.e_val = e_val; t.e_ctrl = e_ctrl; t.e_opa = e_opa; t.e_opb = e_opb;
    t.e_we = e_we; t.e_wa = e_wa; t.e_br = e_br; t.e_ill = e_ill;
    tbl.push_back(t);
  endtask

  initial begin
    logic [19:0] add5, add6, orr;
    bit          r_rst, r_v, r_fl, r_st, r_we;
    logic [2:0]  r_wa;
    logic [3:0]  r_op;
    int          sel, j0;

    for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
    m_bubble();
    m_ill = 0;

    add5 = enc(4'h0, 3'd5, 3'd1, 3'd2);
    add6 = enc(4'h0, 3'd6, 3'd1, 3'd2);
    //   rst v  ins                       fl st we wa wd   rdy  val ctl opa opb we wa br ill
    add(0, 0, NOP,                        0, 0, 0, 0, 0,   -1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, NOP,                        0, 0, 0, 0, 0,   -1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, NOP,                        0, 0, 1, 1, 5,    1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, NOP,                        0, 0, 1, 2, 3,    1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, enc(4'h0, 3'd3, 3'd1, 3'd2),0, 0, 0, 0, 0,    1,  1, 0, 5, 3, 1, 3, 0, 0);
    add(1, 0, NOP,                        0, 0, 1, 3, 8,    1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, add5,                       0, 0, 0, 0, 0,    1,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add5,                       0, 0, 0, 0, 0,    1,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add5,                       0, 0, 0, 0, 0,    1,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add5,                       0, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, add5,                       0, 0, 1, 5, 7,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, add5,                       0, 0, 0, 0, 0,    1,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add6,                       0, 1, 0, 0, 0,    0,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add6,                       0, 1, 0, 0, 0,    0,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add6,                       0, 1, 0, 0, 0,    0,  1, 0, 5, 3, 1, 5, 0, 0);
    add(1, 1, add6,                       0, 0, 0, 0, 0,    1,  1, 0, 5, 3, 1, 6, 0, 0);
    add(1, 1, enc(4'h2, 3'd7, 3'd6, 3'd6),1, 0, 0, 0, 0,    0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, enc(4'h2, 3'd7, 3'd6, 3'd6),0, 0, 0, 0, 0,    1,  1, 2, 0, 0, 1, 7, 0, 0);
    add(1, 1, enc(4'h7, 3'd0, 3'd0, 3'd0),0, 0, 0, 0, 0,    1,  0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, enc(4'h3, 3'd1, 3'd2, 3'd0),0, 0, 0, 0, 0,    1,  1, 3, 3, 0, 1, 1, 0, 0);
    add(1, 0, NOP,                        0, 0, 1, 1, 9,    1,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, enc(4'h4, 3'd0, 3'd1, 3'd2),0, 0, 0, 0, 0,    1,  1, 0, 9, 3, 0, 0, 1, 0);
    add(1, 0, NOP,                        0, 0, 0, 0, 0,    1,  0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].ins, tbl[i].fl, tbl[i].st, tbl[i].we, tbl[i].wa,
           tbl[i].wd, tbl[i].rdy);
      exp_out($sformatf("row%0d", i), tbl[i].e_val, tbl[i].e_ctrl, tbl[i].e_opa,
              tbl[i].e_opb, tbl[i].e_we, tbl[i].e_wa, tbl[i].e_br, tbl[i].e_ill);
    end

    // RAW on r3 released by writeback (r1=9, r2=3 at this point)
    orr = enc(4'h1, 3'd4, 3'd3, 3'd1);
    step(1, 1, enc(4'h0, 3'd3, 3'd1, 3'd2), 0, 0, 0, 0, 0, 1);
    exp_out("raw.add", 1, 0, 9, 3, 1, 3, 0, 0);
    step(1, 1, orr, 0, 0, 0, 0, 0, 0);
    exp_out("raw.stall", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DECODE_WB_BYPASS_EN
    step(1, 1, orr, 0, 0, 1, 3, 8, 1);
    exp_out("raw.bypass", 1, 1, 8, 9, 1, 4, 0, 0);
`else
    step(1, 1, orr, 0, 0, 1, 3, 8, 0);
    exp_out("raw.wbcycle", 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, orr, 0, 0, 0, 0, 0, 1);
    exp_out("raw.issue", 1, 1, 8, 9, 1, 4, 0, 0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r_rst = ($urandom_range(0, 299) != 0);
      sel = $urandom_range(0, 9);
      r_op = (sel < 5) ? 4'(sel) : (sel < 7) ? 4'hF : 4'($urandom_range(5, 14));
      r_v  = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 15) == 0);
      r_st = ($urandom_range(0, 3) == 0);
      r_we = ($urandom_range(0, 2) == 0);
      r_wa = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        j0 = $urandom_range(0, 6);
        for (int j = 0; j < 7; j++) begin
          if (m_cnt[((j0 + j) % 7) + 1] != 0) begin
            r_wa = 3'(((j0 + j) % 7) + 1);
            break;
          end
        end
      end
      step(r_rst, r_v,
           {r_op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 7'($urandom)},
           r_fl, r_st, r_we, r_wa, 20'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
